// File: rtl/fse_lms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fse_lms_pkg
// Brief    : Shared FSM encoding, default sizing and width helpers for the
//            FSE LMS coefficient adapter.
// Revision : 1.0 - initial release
// ============================================================================
package fse_lms_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UPDATE  = 2'd1,
    S_PUBLISH = 2'd2
  } lms_state_e;

  localparam int c_nb_in     = 8;
  localparam int c_nbf_in    = 5;
  localparam int c_nb_err    = 8;
  localparam int c_nbf_err   = 5;
  localparam int c_n_coeff   = 9;
  localparam int c_nb_coeff  = 7;
  localparam int c_nbf_coeff = 5;
  localparam int c_nb_acc    = 16;
  localparam int c_mu_base   = 2;
  localparam int c_init_ctr  = 1;

  localparam int c_nb_prod   = c_nb_err + c_nb_in;
  localparam int c_nbf_acc   = c_nb_acc - c_nb_coeff + c_nbf_coeff;
  localparam int c_acc_align = c_nbf_acc - (c_nbf_err + c_nbf_in);
  localparam int c_ctr_idx   = c_n_coeff / 2;
  localparam int c_nb_idx    = (c_n_coeff > 1) ? $clog2(c_n_coeff) : 1;

  // Accumulator keeps the coefficient's integer bits, so extra precision is all fraction.
  function automatic int f_acc_frac(input int nb_acc, input int nb_coeff, input int nbf_coeff);
    return nb_acc - nb_coeff + nbf_coeff;
  endfunction

  function automatic int f_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lms_tap_mac.sv
`default_nettype none
// ============================================================================
// Module   : lms_tap_mac
// Brief    : Single LMS tap update: err*x, align to accumulator scale, mu
//            shift (floor), saturating add. Shared across taps by the caller.
// Revision : 1.0 - initial release
// ============================================================================
module lms_tap_mac #(
  parameter int NB_IN   = 8,
  parameter int NB_ERR  = 8,
  parameter int NB_ACC  = 16,
  parameter int ALIGN   = 4,
  parameter int MU_BASE = 2
) (
  input  logic signed [NB_ERR-1:0] i_err,
  input  logic signed [NB_IN-1:0]  i_x,
  input  logic        [2:0]        i_mu_sel,
  input  logic signed [NB_ACC-1:0] i_acc,
  output logic signed [NB_ACC-1:0] o_acc
);

  localparam int c_prod_w = NB_ERR + NB_IN;
  localparam int c_term_w = c_prod_w + ((ALIGN > 0) ? ALIGN : 0);
  localparam int c_sum_w  = ((c_term_w > NB_ACC) ? c_term_w : NB_ACC) + 1;

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_term_w-1:0] w_aligned;
  logic signed [c_term_w-1:0] w_term;
  logic        [4:0]          w_shamt;
  logic signed [c_sum_w-1:0]  w_sum;
  logic                       w_ovf;

  assign w_prod = c_prod_w'(i_err) * c_prod_w'(i_x);

  if (ALIGN >= 0) begin : g_align_left
    assign w_aligned = c_term_w'(w_prod) <<< ALIGN;
  end else begin : g_align_right
    assign w_aligned = w_prod >>> (-ALIGN);
  end

  assign w_shamt = 5'(MU_BASE) + 5'(i_mu_sel);
  assign w_term  = w_aligned >>> w_shamt;
  assign w_sum   = c_sum_w'(w_term) + c_sum_w'(i_acc);

  // Overflow whenever the bits above the accumulator sign disagree with the true sign.
  assign w_ovf = (w_sum[c_sum_w-1:NB_ACC-1] != {(c_sum_w-NB_ACC+1){w_sum[c_sum_w-1]}});

  always_comb begin
    o_acc = w_sum[NB_ACC-1:0];
    if (w_ovf) begin
      o_acc = w_sum[c_sum_w-1] ? {1'b1, {(NB_ACC-1){1'b0}}} : {1'b0, {(NB_ACC-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lms_coeff_adapter.sv
`default_nettype none
// ============================================================================
// Module   : lms_coeff_adapter
// Brief    : LMS coefficient engine for the FSE. Serial one-tap-per-cycle
//            update per error sample, atomic publish of the coefficient bus.
// Revision : 1.0 - initial release
// ============================================================================
module lms_coeff_adapter
  import fse_lms_pkg::*;
#(
  parameter int NB_IN     = c_nb_in,
  parameter int NBF_IN    = c_nbf_in,
  parameter int NB_ERR    = c_nb_err,
  parameter int NBF_ERR   = c_nbf_err,
  parameter int N_COEFF   = c_n_coeff,
  parameter int NB_COEFF  = c_nb_coeff,
  parameter int NBF_COEFF = c_nbf_coeff,
  parameter int NB_ACC    = c_nb_acc,
  parameter int MU_BASE   = c_mu_base,
  parameter int INIT_CTR  = c_init_ctr
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_x_valid,
  input  logic signed [NB_IN-1:0]       i_x,
  input  logic                          i_err_valid,
  input  logic signed [NB_ERR-1:0]      i_err,
  input  logic        [2:0]             i_mu_sel,
  input  logic                          i_freeze,
  output logic                          o_err_ready,
  output logic                          o_err_overrun,
  output logic [N_COEFF*NB_COEFF-1:0]   o_coeff,
  output logic                          o_coeff_valid
);

  localparam int c_acc_frac = f_acc_frac(NB_ACC, NB_COEFF, NBF_COEFF);
  localparam int c_align    = c_acc_frac - (NBF_ERR + NBF_IN);
  localparam int c_center   = N_COEFF / 2;
  localparam int c_idx_w    = f_idx_bits(N_COEFF);

  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(N_COEFF - 1);
  localparam logic [NB_ACC-1:0]   c_acc_one   = NB_ACC'(1) << c_acc_frac;
  localparam logic [NB_COEFF-1:0] c_coeff_one = NB_COEFF'(1) << NBF_COEFF;

  lms_state_e r_state;
  lms_state_e w_state_nxt;
  logic       w_accept;
  logic       w_step;
  logic       w_publish;
  logic       w_drop;

  logic signed [NB_IN-1:0]    r_xdl [N_COEFF];
  logic signed [NB_IN-1:0]    r_xs  [N_COEFF];
  logic signed [NB_ACC-1:0]   r_acc [N_COEFF];
  logic        [NB_COEFF-1:0] r_coeff [N_COEFF];
  logic signed [NB_ERR-1:0]   r_err;
  logic        [2:0]          r_mu;
  logic        [c_idx_w-1:0]  r_idx;
  logic                       r_coeff_valid;
  logic                       r_overrun;
  logic signed [NB_ACC-1:0]   w_mac_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_publish   = 1'b0;
    o_err_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_err_ready = 1'b1;
        if (i_err_valid && !i_freeze) begin
          w_accept    = 1'b1;
          w_state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_step = 1'b1;
        if (r_idx == c_last_idx) begin
          w_state_nxt = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        w_publish   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_drop = i_err_valid && !i_freeze && (r_state != S_IDLE);

  // The regressor line keeps shifting during an update; the snapshot in r_xs is what taps use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_COEFF; i++) begin
        r_xdl[i] <= '0;
      end
    end else if (i_x_valid) begin
      r_xdl[0] <= i_x;
      for (int i = 1; i < N_COEFF; i++) begin
        r_xdl[i] <= r_xdl[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_COEFF; i++) begin
        r_xs[i] <= '0;
      end
      r_err <= '0;
      r_mu  <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_xs  <= r_xdl;
      r_err <= i_err;
      r_mu  <= i_mu_sel;
      r_idx <= '0;
    end else if (w_step) begin
      r_idx <= r_idx + c_idx_w'(1);
    end
  end

  lms_tap_mac #(
    .NB_IN   (NB_IN),
    .NB_ERR  (NB_ERR),
    .NB_ACC  (NB_ACC),
    .ALIGN   (c_align),
    .MU_BASE (MU_BASE)
  ) u_mac (
    .i_err    (r_err),
    .i_x      (r_xs[r_idx]),
    .i_mu_sel (r_mu),
    .i_acc    (r_acc[r_idx]),
    .o_acc    (w_mac_acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_COEFF; i++) begin
        r_acc[i]   <= ((INIT_CTR != 0) && (i == c_center)) ? c_acc_one : '0;
        r_coeff[i] <= ((INIT_CTR != 0) && (i == c_center)) ? c_coeff_one : '0;
      end
      r_coeff_valid <= 1'b0;
    end else begin
      r_coeff_valid <= w_publish;
      if (w_step) begin
        r_acc[r_idx] <= w_mac_acc;
      end
      if (w_publish) begin
        for (int i = 0; i < N_COEFF; i++) begin
          r_coeff[i] <= r_acc[i][NB_ACC-1 -: NB_COEFF];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_COEFF; gi++) begin : g_pack
    assign o_coeff[NB_COEFF*(gi+1)-1 -: NB_COEFF] = r_coeff[gi];
  end

  assign o_coeff_valid = r_coeff_valid;
  assign o_err_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lms_coeff_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_coeff_adapter
// Brief    : Directed self-checking bench for lms_coeff_adapter with an
//            arithmetic reference model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms_coeff_adapter;

  localparam int N   = 9;
  localparam int NBC = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              x_valid;
  logic signed [7:0] x;
  logic              err_valid;
  logic signed [7:0] err;
  logic        [2:0] mu_sel;
  logic              freeze;
  logic              o_err_ready;
  logic              o_err_overrun;
  logic [N*NBC-1:0]  o_coeff;
  logic              o_coeff_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cv_count = 0;

  lms_coeff_adapter dut (
    .clk           (clk),
    .reset         (reset),
    .i_x_valid     (x_valid),
    .i_x           (x),
    .i_err_valid   (err_valid),
    .i_err         (err),
    .i_mu_sel      (mu_sel),
    .i_freeze      (freeze),
    .o_err_ready   (o_err_ready),
    .o_err_overrun (o_err_overrun),
    .o_coeff       (o_coeff),
    .o_coeff_valid (o_coeff_valid)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: whole update computed at acceptance with plain integer maths.
  int         m_xdl [N];
  int         m_acc [N];
  logic [6:0] m_pend [N];
  logic [6:0] m_coeff [N];
  int         m_busy;
  bit         m_cv;
  bit         m_ovf;

  function automatic void model_init();
    for (int i = 0; i < N; i++) begin
      m_xdl[i]   = 0;
      m_acc[i]   = (i == N/2) ? 16384 : 0;
      m_coeff[i] = (i == N/2) ? 7'h20 : 7'h00;
      m_pend[i]  = m_coeff[i];
    end
    m_busy = 0;
    m_cv   = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  task automatic model_step();
    bit was_busy;
    int p;
    int t;
    int s;
    was_busy = (m_busy != 0);
    m_cv = 1'b0;
    if (err_valid && !freeze) begin
      if (!was_busy) begin
        for (int i = 0; i < N; i++) begin
          p = int'(err) * m_xdl[i];
          t = (p * 16) >>> (2 + int'(mu_sel));
          s = m_acc[i] + t;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          m_acc[i]  = s;
          m_pend[i] = 7'(s >>> 9);
        end
        m_busy = N + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (was_busy) begin
      m_busy--;
      if (m_busy == 0) begin
        m_coeff = m_pend;
        m_cv    = 1'b1;
      end
    end
    if (x_valid) begin
      for (int i = N-1; i > 0; i--) m_xdl[i] = m_xdl[i-1];
      m_xdl[0] = int'(x);
    end
  endtask

  function automatic logic [N*NBC-1:0] model_set();
    logic [N*NBC-1:0] v;
    for (int i = 0; i < N; i++) v[NBC*i +: NBC] = m_coeff[i];
    return v;
  endfunction

  function automatic logic [N*NBC-1:0] lit_set(input logic [6:0] ctr, input logic [6:0] oth);
    logic [N*NBC-1:0] v;
    for (int i = 0; i < N; i++) v[NBC*i +: NBC] = (i == N/2) ? ctr : oth;
    return v;
  endfunction

  initial begin
    model_init();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_init();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_coeff",   64'(o_coeff),       64'(model_set()));
    chk("cyc_valid",   64'(o_coeff_valid), 64'(m_cv));
    chk("cyc_ready",   64'(o_err_ready),   64'(m_busy == 0));
    chk("cyc_overrun", 64'(o_err_overrun), 64'(m_ovf));
    if (o_coeff_valid) cv_count++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_x(input logic signed [7:0] v);
    x_valid = 1'b1;
    x = v;
    repeat (N) tick();
    x_valid = 1'b0;
  endtask

  task automatic send_err(input logic signed [7:0] e, input logic [2:0] mu);
    err_valid = 1'b1;
    err = e;
    mu_sel = mu;
    tick();
    err_valid = 1'b0;
  endtask

  task automatic wait_cv(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_coeff_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int cv0;

  initial begin
    x_valid = 1'b0; x = '0; err_valid = 1'b0; err = '0; mu_sel = '0; freeze = 1'b0;
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_coeff",   64'(o_coeff), 64'(lit_set(7'h20, 7'h00)));
    chk("rst_ready",   64'(o_err_ready), 64'd1);
    chk("rst_valid",   64'(o_coeff_valid), 64'd0);
    chk("rst_overrun", 64'(o_err_overrun), 64'd0);

    // Basic update, x=1.0, err=0.5, mu=0
    load_x(8'sh20);
    send_err(8'sh10, 3'd0);
    wait_cv(lat);
    chk("basic_latency", 64'(lat), 64'd10);
    chk("basic_coeff", 64'(o_coeff), 64'(lit_set(7'h24, 7'h04)));
    chk("basic_model", 64'(model_set()), 64'(lit_set(7'h24, 7'h04)));
    tick();
    chk("basic_ready", 64'(o_err_ready), 64'd1);

    // Positive saturation
    pulse_reset();
    load_x(8'sh7F);
    send_err(8'sh7F, 3'd0);
    wait_cv(lat);
    send_err(8'sh7F, 3'd0);
    wait_cv(lat);
    chk("satp_latency", 64'(lat), 64'd10);
    chk("satp_coeff", 64'(o_coeff), 64'(lit_set(7'h3F, 7'h3F)));
    chk("satp_model", 64'(model_set()), 64'(lit_set(7'h3F, 7'h3F)));

    // Negative saturation
    pulse_reset();
    load_x(8'sh7F);
    send_err(-8'sh7F, 3'd0);
    wait_cv(lat);
    send_err(-8'sh7F, 3'd0);
    wait_cv(lat);
    chk("satn_coeff", 64'(o_coeff), 64'(lit_set(7'h40, 7'h40)));
    chk("satn_model", 64'(model_set()), 64'(lit_set(7'h40, 7'h40)));

    // Larger mu shift: 0.5 >> 3 = 0.0625 -> truncated to coefficient 0.0625 = 7'h02
    pulse_reset();
    load_x(8'sh20);
    send_err(8'sh10, 3'd1);
    wait_cv(lat);
    chk("mu1_coeff", 64'(o_coeff), 64'(lit_set(7'h22, 7'h02)));

    // Overrun: second error dropped mid-update
    pulse_reset();
    load_x(8'sh20);
    cv0 = cv_count;
    send_err(8'sh10, 3'd0);
    tick(); tick();
    err_valid = 1'b1;
    err = 8'sh30;
    tick();
    err_valid = 1'b0;
    repeat (20) tick();
    chk("ovr_flag", 64'(o_err_overrun), 64'd1);
    chk("ovr_pulses", 64'(cv_count - cv0), 64'd1);
    chk("ovr_coeff", 64'(o_coeff), 64'(lit_set(7'h24, 7'h04)));

    // Reset in the middle of an update
    pulse_reset();
    load_x(8'sh20);
    cv0 = cv_count;
    send_err(8'sh10, 3'd0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("midrst_coeff", 64'(o_coeff), 64'(lit_set(7'h20, 7'h00)));
    chk("midrst_ready", 64'(o_err_ready), 64'd1);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("midrst_pulses", 64'(cv_count - cv0), 64'd0);
    chk("midrst_coeff2", 64'(o_coeff), 64'(lit_set(7'h20, 7'h00)));

    // Freeze ignores errors
    load_x(8'sh20);
    cv0 = cv_count;
    freeze = 1'b1;
    err_valid = 1'b1;
    err = 8'sh10;
    repeat (3) tick();
    err_valid = 1'b0;
    freeze = 1'b0;
    repeat (12) tick();
    chk("frz_pulses", 64'(cv_count - cv0), 64'd0);
    chk("frz_overrun", 64'(o_err_overrun), 64'd0);
    chk("frz_coeff", 64'(o_coeff), 64'(lit_set(7'h20, 7'h00)));

    // New x samples during UPDATE do not disturb the snapshot
    send_err(8'sh10, 3'd0);
    x_valid = 1'b1;
    x = 8'sh7F;
    wait_cv(lat);
    x_valid = 1'b0;
    chk("xdur_latency", 64'(lat), 64'd10);
    chk("xdur_coeff", 64'(o_coeff), 64'(lit_set(7'h24, 7'h04)));
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
